npp_flit_rx_buffer: RTL

- Downstream stage of the NPP input interface.
- Consumes the packed flit word (valid bit in the MSB, data below) together with the head/tail flags.
- Checks packet framing, buffers flits in a synchronous FIFO, and presents a valid/ready flit stream with head/tail sidebands to the noc2axi conversion logic.
- Reports FIFO occupancy, the number of complete packets buffered, and sticky error flags.

---
 rtl/npp_flit_rx_buffer_if.sv | 16 +
 rtl/npp_flit_rx_buffer.sv | 72 +++++++
 2 files changed

// File: rtl/npp_flit_rx_buffer_if.sv
// npp_flit_rx_buffer_if: flit bundle between the NPP input side, the rx buffer and the noc2axi consumer.
//   noc_data/head/tail : packed input flit (valid in MSB) and framing flags
//   out_*              : valid/ready flit stream with head/tail sidebands
//   slave modport      : the rx buffer; master modport: the surrounding logic
interface npp_flit_rx_buffer_if #(parameter int DATA_WIDTH = 128);
    logic [DATA_WIDTH:0]   noc_data;
    logic                  head;
    logic                  tail;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_head;
    logic                  out_tail;
    modport slave (input noc_data, head, tail, out_ready, output out_valid, out_data, out_head, out_tail);
    modport master (output noc_data, head, tail, out_ready, input out_valid, out_data, out_head, out_tail);
endinterface

// File: rtl/npp_flit_rx_buffer.sv
// npp_flit_rx_buffer: framing check and flit FIFO between the NPP input interface and noc2axi.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bif          : flit input and valid/ready flit output (slave modport)
//   err_clr      : synchronous clear of the sticky error flags
//   fifo_count   : flits stored; pkt_count: stored tail flits (complete packets)
//   framing_err  : sticky framing violation; overflow_err: sticky in-frame flit lost to a full FIFO
module npp_flit_rx_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    npp_flit_rx_buffer_if.slave    bif,
    input  logic                   err_clr,
    output logic [CNT_WIDTH-1:0]   fifo_count,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic                   framing_err,
    output logic                   overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
    state_t                state;
    logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
    logic                  in_flit, store_req, bad_frame, rd, can_wr, wr, lost;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [DATA_WIDTH+1:0] wr_word, front;
    assign in_flit    = bif.noc_data[DATA_WIDTH];
    assign store_req  = in_flit && (state == IDLE ? bif.head : state == IN_PKT && !bif.head);
    assign bad_frame  = in_flit && (state == IDLE ? !bif.head : state == IN_PKT && bif.head);
    assign rd         = bif.out_valid && bif.out_ready;
    // A full FIFO still takes a flit when the same cycle frees a slot by reading.
    assign can_wr     = fifo_count != CNT_WIDTH'(FIFO_DEPTH) || rd;
    assign wr         = store_req && can_wr;
    assign lost       = store_req && !can_wr;
    assign wr_word    = {bif.head, bif.tail, bif.noc_data[DATA_WIDTH-1:0]};
    assign rd_ptr_nxt = rd_ptr + AW'(rd);
    assign count_nxt  = fifo_count + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
    // The registered output stage preloads the next front entry; when that entry is
    // the one being written right now it bypasses the memory.
    assign front      = wr && count_nxt == CNT_WIDTH'(1) ? wr_word : mem[rd_ptr_nxt];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_word;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            pkt_count     <= '0;
            framing_err   <= 1'b0;
            overflow_err  <= 1'b0;
            bif.out_valid <= 1'b0;
            bif.out_data  <= '0;
            bif.out_head  <= 1'b0;
            bif.out_tail  <= 1'b0;
        end else begin
            // Any unstored, non-tail flit leaves the FSM dropping until the next tail.
            if (in_flit) state <= bif.tail ? IDLE : wr ? IN_PKT : DROP;
            wr_ptr        <= wr_ptr + AW'(wr);
            rd_ptr        <= rd_ptr_nxt;
            fifo_count    <= count_nxt;
            pkt_count     <= pkt_count + CNT_WIDTH'(wr && bif.tail) - CNT_WIDTH'(rd && bif.out_tail);
            framing_err   <= bad_frame || (framing_err && !err_clr);
            overflow_err  <= lost || (overflow_err && !err_clr);
            bif.out_valid <= count_nxt != '0;
            if (count_nxt != '0) {bif.out_head, bif.out_tail, bif.out_data} <= front;
        end
    end
endmodule
